// File: rtl/adr_pkg.sv
// Shared definitions for the adder family: sub encoding and parameter legality check.
// Latency: n/a (package).
// Backpressure: n/a (package).
`ifndef ADR_PKG_SV
`define ADR_PKG_SV

// Elaboration-time guard: width must split into equal, non-empty chunks.
`define ADR_CHECK_PARAMS(W, S) \
    if ((W) < 1 || (S) < 1 || (S) > (W) || ((W) % (S)) != 0) begin : g_bad_params \
        $error("adr: illegal WIDTH/STAGES combination"); \
    end

package adr_pkg;
    localparam logic ADR_ADD = 1'b0;
    localparam logic ADR_SUB = 1'b1;
endpackage

`endif

// File: rtl/adr_pipe_rca_if.sv
// Operand/result handshake bundle for the pipelined adder.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready travel through this bundle.
interface adr_pipe_rca_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    // Producer/consumer side (drives operands, consumes results).
    modport master (
        output x, y, cin, sub, in_valid, out_ready,
        input  in_ready, sum, cout, ovf, out_valid
    );

    // Adder side.
    modport slave (
        input  x, y, cin, sub, in_valid, out_ready,
        output in_ready, sum, cout, ovf, out_valid
    );
endinterface

// File: rtl/adr_chunk.sv
// Combinational CHUNK-bit ripple adder slice; also exports the carry into its MSB.
// Latency: 0 (pure combinational).
// Backpressure: none.
module adr_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [CHUNK:0] c;

    // Bit-serial ripple: c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/adr_pipe_rca.sv
// Pipelined ripple-carry add/sub, one CHUNK of carry chain per stage, one op/cycle.
// Latency: STAGES cycles from accept to out_valid, plus one per stall cycle.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready = !out_valid || out_ready.
module adr_pipe_rca
    import adr_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic           clk,
    input logic           rst,
    adr_pipe_rca_if.slave bus
);
    `ADR_CHECK_PARAMS(WIDTH, STAGES)

    localparam int CHUNK = WIDTH / STAGES;

    // Slot k feeds stage k. pa carries finished result chunks below chunk k and
    // untouched x chunks from k upward, so one word serves as skew and de-skew.
    logic [WIDTH-1:0] pa     [STAGES];
    logic [WIDTH-1:0] pb     [STAGES];
    logic             pc     [STAGES];
    logic             pv     [STAGES];
    logic [WIDTH-1:0] nxt_pa [STAGES];
    logic [CHUNK-1:0] s      [STAGES];
    logic             co     [STAGES];
    logic             cm     [STAGES];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic             adv;

    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adr_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (pa[k][k*CHUNK +: CHUNK]),
            .b        (pb[k][k*CHUNK +: CHUNK]),
            .ci       (pc[k]),
            .s        (s[k]),
            .co       (co[k]),
            .c_msb_in (cm[k])
        );
    end

    // Splice each stage's fresh result chunk into the word it passes on.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_pa[k] = pa[k];
            nxt_pa[k][k*CHUNK +: CHUNK] = s[k];
        end
    end

    // Lock-step pipeline advance; empty slots move like data, everything holds on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                pa[k] <= '0;
                pb[k] <= '0;
                pc[k] <= 1'b0;
                pv[k] <= 1'b0;
            end
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            // Subtraction is folded in here: invert y and force carry-in to 1.
            pv[0] <= bus.in_valid;
            pa[0] <= bus.x;
            pb[0] <= (bus.sub == ADR_SUB) ? ~bus.y : bus.y;
            pc[0] <= (bus.sub == ADR_ADD) ? bus.cin : 1'b1;
            for (int k = 1; k < STAGES; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= nxt_pa[k-1];
                pb[k] <= pb[k-1];
                pc[k] <= co[k-1];
            end
            out_valid_q <= pv[STAGES-1];
            sum_q       <= nxt_pa[STAGES-1];
            cout_q      <= co[STAGES-1];
            ovf_q       <= co[STAGES-1] ^ cm[STAGES-1];
        end
    end
endmodule

// File: tb/tb_adr_pipe_rca.sv
// Bench for adr_pipe_rca: directed cases on a 16/4 pipe plus random streams on several shapes.
// Latency: n/a.
// Backpressure: random out_ready toggling exercises stalls.
module tb_adr_pipe_rca;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [3:0] gdone = 4'h0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic cin, input logic sub);
        longint unsigned mask, xx, yy, full, sx, sy, ss;
        exp_t e;
        mask   = (64'd1 << w) - 64'd1;
        xx     = {32'd0, x} & mask;
        yy     = sub ? (~{32'd0, y}) & mask : ({32'd0, y} & mask);
        full   = xx + yy + (sub ? 64'd1 : {63'd0, cin});
        e.sum  = 32'(full & mask);
        e.cout = 1'((full >> w) & 64'd1);
        sx     = (xx >> (w - 1)) & 64'd1;
        sy     = (yy >> (w - 1)) & 64'd1;
        ss     = (full >> (w - 1)) & 64'd1;
        e.ovf  = (sx == sy) && (ss != sx);
        return e;
    endfunction

    function automatic int cfg_w(input int i);
        case (i)
            0: return 16;
            1: return 16;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: return 1;
            1: return 16;
            2: return 2;
            default: return 4;
        endcase
    endfunction

    // ---------------- main 16/4 instance ----------------
    logic rst;
    adr_pipe_rca_if #(.WIDTH(16)) m_if ();
    adr_pipe_rca #(.WIDTH(16), .STAGES(4)) u_dut (.clk(clk), .rst(rst), .bus(m_if));

    exp_t mq[$];
    int   res_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_in_ready", m_if.in_ready, 1);
        end else begin
            chk("in_ready_rule", m_if.in_ready, !m_if.out_valid || m_if.out_ready);
            if (m_if.out_valid && mq.size() == 0)
                chk("spurious_out_valid", m_if.out_valid, 0);
            else if (m_if.out_valid && m_if.out_ready) begin
                e = mq.pop_front();
                res_cnt++;
                chk("m_sum", m_if.sum, e.sum[15:0]);
                chk("m_cout", m_if.cout, e.cout);
                chk("m_ovf", m_if.ovf, e.ovf);
            end
            if (m_if.in_valid && m_if.in_ready)
                mq.push_back(model(16, 32'(m_if.x), 32'(m_if.y), m_if.cin, m_if.sub));
        end
    end

    task automatic run_dir(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input logic sb, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        lat = 0;
        m_if.x = a; m_if.y = b; m_if.cin = ci; m_if.sub = sb;
        m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (m_if.out_valid) begin
                lat = k;
                break;
            end
        end
        chk("dir_latency", lat, 4);
        if (lat != 0) begin
            chk("dir_sum", m_if.sum, es);
            chk("dir_cout", m_if.cout, ec);
            chk("dir_ovf", m_if.ovf, eo);
        end
    endtask

    task automatic drain_main();
        m_if.in_valid = 1'b0;
        m_if.out_ready = 1'b1;
        for (int k = 0; k < 100 && mq.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", mq.size(), 0);
    endtask

    initial begin
        exp_t e;
        int low_cnt, got, acc, cyc;
        logic [15:0] a, b;
        rst = 1'b1;
        m_if.x = '0; m_if.y = '0; m_if.cin = 1'b0; m_if.sub = 1'b0;
        m_if.in_valid = 1'b0; m_if.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", m_if.out_valid, 0);
        chk("rst_sum", m_if.sum, 0);
        chk("rst_cout", m_if.cout, 0);
        chk("rst_ovf", m_if.ovf, 0);
        chk("rst_ready", m_if.in_ready, 1);
        @(posedge clk); #1 rst = 1'b0;

        // Directed literal cases.
        run_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_dir(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        run_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_dir(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain_main();

        // 8 back-to-back ops with a 3-cycle output stall.
        got = res_cnt; acc = 0; low_cnt = 0; cyc = 0;
        while (acc < 8 && cyc < 100) begin
            m_if.x = 16'($urandom); m_if.y = 16'($urandom);
            m_if.cin = 1'($urandom); m_if.sub = 1'($urandom);
            m_if.in_valid = 1'b1;
            m_if.out_ready = !(cyc >= 5 && cyc < 8);
            @(negedge clk);
            if (!m_if.in_ready) low_cnt++;
            if (m_if.in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        drain_main();
        chk("stall_low_cycles", low_cnt, 3);
        chk("stream_results", res_cnt - got, 8);

        // Reset mid-flight: three ops must vanish.
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_if.x = 16'($urandom); m_if.y = 16'($urandom);
            m_if.cin = 1'($urandom); m_if.sub = 1'b0; m_if.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        m_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", m_if.out_valid, 0);
        chk("async_rst_in_ready", m_if.in_ready, 1);
        mq.delete();
        #1 rst = 1'b0;
        got = res_cnt;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", m_if.out_valid, 0);
        end
        chk("post_rst_no_results", res_cnt - got, 0);
        a = 16'($urandom); b = 16'($urandom);
        e = model(16, 32'(a), 32'(b), 1'b1, 1'b0);
        run_dir(a, b, 1'b1, 1'b0, e.sum[15:0], e.cout, e.ovf);
        drain_main();

        // Random traffic on the main instance.
        got = res_cnt; acc = 0;
        for (int c = 0; c < 20000 && acc < 1000; c++) begin
            m_if.in_valid = ($urandom_range(0, 3) != 0);
            m_if.out_ready = ($urandom_range(0, 3) != 0);
            m_if.x = 16'($urandom); m_if.y = 16'($urandom);
            m_if.cin = 1'($urandom); m_if.sub = 1'($urandom);
            @(negedge clk);
            if (m_if.in_valid && m_if.in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("main_rand_accepts", acc >= 1000, 1);
        drain_main();
        chk("main_rand_results", res_cnt - got, acc);

        for (int i = 0; i < 30000 && gdone != 4'hF; i++) @(posedge clk);
        chk("cfg_all_done", gdone, 4'hF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- random-only instances of other shapes ----------------
    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);
        logic grst;
        adr_pipe_rca_if #(.WIDTH(W)) gif ();
        adr_pipe_rca #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(grst), .bus(gif));
        exp_t q[$];
        int acc = 0;
        int got = 0;

        always @(negedge clk) begin
            exp_t e;
            if (!grst) begin
                if (gif.out_valid && q.size() == 0)
                    chk("g_spurious", gif.out_valid, 0);
                else if (gif.out_valid && gif.out_ready) begin
                    e = q.pop_front();
                    got++;
                    chk("g_sum", 64'(gif.sum), 64'(e.sum[W-1:0]));
                    chk("g_cout", gif.cout, e.cout);
                    chk("g_ovf", gif.ovf, e.ovf);
                end
                if (gif.in_valid && gif.in_ready) begin
                    acc++;
                    q.push_back(model(W, 32'(gif.x), 32'(gif.y), gif.cin, gif.sub));
                end
            end
        end

        initial begin
            grst = 1'b1;
            gif.x = '0; gif.y = '0; gif.cin = 1'b0; gif.sub = 1'b0;
            gif.in_valid = 1'b0; gif.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 grst = 1'b0;
            for (int c = 0; c < 20000 && acc < 1000; c++) begin
                gif.in_valid = ($urandom_range(0, 3) != 0);
                gif.out_ready = ($urandom_range(0, 3) != 0);
                gif.x = W'($urandom); gif.y = W'($urandom);
                gif.cin = 1'($urandom); gif.sub = 1'($urandom);
                @(posedge clk); #1;
            end
            gif.in_valid = 1'b0;
            gif.out_ready = 1'b1;
            for (int k = 0; k < 200 && q.size() != 0; k++) begin
                @(posedge clk); #1;
            end
            chk("g_accepts", acc >= 1000, 1);
            chk("g_drained", q.size(), 0);
            chk("g_results", got, acc);
            gdone[g] = 1'b1;
        end
    end
endmodule
